pid_sequencer: RTL and testbench

- Sample-rate controller for the loop's error/control datapath: on each sample tick it captures ref and yk, forms the saturated error e[k] = ref - yk and keeps an error history.
- It then schedules one shared signed multiplier over three coefficient products to evaluate the incremental PID law u[k] = u[k-1] + a0*e[k] + a1*e[k-1] + a2*e[k-2].
- Sits between the ADC/reference registers and the actuator output register; all values are signed Q(N-F).F fixed point.

---
 rtl/pid_sequencer_if.sv | 27 ++
 rtl/pid_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pid_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_sequencer_if.sv
// Handshake bundle between the sample-rate controller and its surrounding registers.
// refk carries the reference sample; yk the plant output sampled at the same tick.
interface pid_if #(
  parameter int unsigned N = 18
);
  logic                clear;
  logic                sample_tick;
  logic signed [N-1:0] refk;
  logic signed [N-1:0] yk;
  logic signed [N-1:0] a0;
  logic signed [N-1:0] a1;
  logic signed [N-1:0] a2;
  logic signed [N-1:0] u_out;
  logic                u_valid;
  logic                busy;
  logic                overrun;

  modport master (
    output clear, sample_tick, refk, yk, a0, a1, a2,
    input  u_out, u_valid, busy, overrun
  );

  modport slave (
    input  clear, sample_tick, refk, yk, a0, a1, a2,
    output u_out, u_valid, busy, overrun
  );
endinterface

// File: rtl/pid_sequencer.sv
// Incremental PID step controller: captures the error on a sample tick, then time-shares
// one signed multiplier over three coefficient products and saturates the result.
module pid_sequencer #(
  parameter int unsigned N = 18,
  parameter int unsigned F = 9,
  parameter int unsigned G = 4
) (
  input logic  clk,
  input logic  rst_n,
  pid_if.slave bus
);

  localparam int unsigned W = N + G;
  localparam int unsigned P = 2 * N;
  localparam logic signed [N-1:0] MaxVal = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MinVal = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMac0, StMac1, StMac2, StSat} state_e;

  state_e              state_q, state_d;
  logic signed [N-1:0] e0_q, e0_d, e1_q, e1_d, e2_q, e2_d;
  logic signed [N-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
  logic signed [N-1:0] u_prev_q, u_prev_d;
  logic signed [N-1:0] u_out_q, u_out_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic                u_valid_q, u_valid_d;
  logic                overrun_q, overrun_d;
  logic                busy_q;

  logic signed [N:0]   diff;
  logic signed [N-1:0] err_sat;
  logic signed [N-1:0] mul_a, mul_b;
  logic signed [P-1:0] prod;
  logic signed [W-1:0] term;
  logic signed [W-1:0] u_prev_x;
  logic [G:0]          acc_top;
  logic signed [N-1:0] acc_sat;

  // Error formed one bit wider so ref - yk can never wrap before clamping.
  always_comb begin
    diff = {bus.refk[N-1], bus.refk} - {bus.yk[N-1], bus.yk};
    if (diff[N] != diff[N-1]) begin
      err_sat = diff[N] ? MinVal : MaxVal;
    end else begin
      err_sat = diff[N-1:0];
    end
  end

  // Single shared multiplier; operands are steered by the MAC phase.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      StMac0:  begin mul_a = c0_q; mul_b = e0_q; end
      StMac1:  begin mul_a = c1_q; mul_b = e1_q; end
      StMac2:  begin mul_a = c2_q; mul_b = e2_q; end
      default: ;
    endcase
    prod     = P'(mul_a) * P'(mul_b);
    term     = W'(prod >>> F);
    u_prev_x = W'(u_prev_q);
  end

  // Guard bits plus the N-bit sign bit must agree for the value to fit in N bits.
  always_comb begin
    acc_top = acc_q[W-1:N-1];
    if ((&acc_top) || !(|acc_top)) begin
      acc_sat = acc_q[N-1:0];
    end else begin
      acc_sat = acc_q[W-1] ? MinVal : MaxVal;
    end
  end

  always_comb begin
    state_d   = state_q;
    e0_d      = e0_q;
    e1_d      = e1_q;
    e2_d      = e2_q;
    c0_d      = c0_q;
    c1_d      = c1_q;
    c2_d      = c2_q;
    u_prev_d  = u_prev_q;
    acc_d     = acc_q;
    u_out_d   = u_out_q;
    u_valid_d = 1'b0;
    overrun_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.clear) begin
          e0_d     = '0;
          e1_d     = '0;
          e2_d     = '0;
          u_prev_d = '0;
        end else if (bus.sample_tick) begin
          e2_d    = e1_q;
          e1_d    = e0_q;
          e0_d    = err_sat;
          c0_d    = bus.a0;
          c1_d    = bus.a1;
          c2_d    = bus.a2;
          state_d = StMac0;
        end
      end
      StMac0: begin
        acc_d   = u_prev_x + term;
        state_d = StMac1;
      end
      StMac1: begin
        acc_d   = acc_q + term;
        state_d = StMac2;
      end
      StMac2: begin
        acc_d   = acc_q + term;
        state_d = StSat;
      end
      StSat: begin
        u_out_d   = acc_sat;
        u_prev_d  = acc_sat;
        u_valid_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Clear aborts a step in flight and wins over any tick arriving with it.
    if (state_q != StIdle) begin
      if (bus.clear) begin
        state_d   = StIdle;
        e0_d      = '0;
        e1_d      = '0;
        e2_d      = '0;
        u_prev_d  = '0;
        u_out_d   = u_out_q;
        u_valid_d = 1'b0;
      end else begin
        overrun_d = bus.sample_tick;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      e0_q      <= '0;
      e1_q      <= '0;
      e2_q      <= '0;
      c0_q      <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      u_prev_q  <= '0;
      acc_q     <= '0;
      u_out_q   <= '0;
      u_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      e0_q      <= e0_d;
      e1_q      <= e1_d;
      e2_q      <= e2_d;
      c0_q      <= c0_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      u_prev_q  <= u_prev_d;
      acc_q     <= acc_d;
      u_out_q   <= u_out_d;
      u_valid_q <= u_valid_d;
      overrun_q <= overrun_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign bus.u_out   = u_out_q;
  assign bus.u_valid = u_valid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_pid_sequencer.sv
// Bench for pid_sequencer: directed scenarios with literal results plus a randomized run,
// all outputs checked every cycle against a step-level reference model.
module tb_pid_sequencer;

  localparam int unsigned N = 18;
  localparam int unsigned F = 9;
  localparam int unsigned G = 4;
  localparam longint UMax = (longint'(1) <<< (N - 1)) - 1;
  localparam longint UMin = -(longint'(1) <<< (N - 1));

  logic clk;
  logic rst_n;
  pid_if #(.N(N)) bus ();

  pid_sequencer #(.N(N), .F(F), .G(G)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one whole step evaluated at capture) ----------------
  longint m_e[3];
  longint m_u_prev;
  longint m_res;
  longint exp_u;
  int     left;
  longint exp_valid, exp_busy, exp_over;

  function automatic longint clamp(input longint x);
    if (x > UMax) return UMax;
    if (x < UMin) return UMin;
    return x;
  endfunction

  function automatic longint wrap_acc(input longint x);
    logic signed [N+G-1:0] w;
    w = x[N+G-1:0];
    return longint'(w);
  endfunction

  task automatic model_reset();
    m_e[0] = 0; m_e[1] = 0; m_e[2] = 0;
    m_u_prev = 0; m_res = 0; exp_u = 0; left = 0;
    exp_valid = 0; exp_busy = 0; exp_over = 0;
  endtask

  task automatic model_zero_history();
    m_e[0] = 0; m_e[1] = 0; m_e[2] = 0;
    m_u_prev = 0;
  endtask

  // Predicts outputs after the coming rising edge from the inputs now applied.
  task automatic model_advance();
    longint acc;
    exp_valid = 0;
    exp_over  = 0;
    if (left > 0) begin
      if (bus.clear) begin
        left = 0;
        model_zero_history();
      end else begin
        if (bus.sample_tick) exp_over = 1;
        left--;
        if (left == 0) begin
          exp_u     = m_res;
          m_u_prev  = m_res;
          exp_valid = 1;
        end
      end
    end else if (bus.clear) begin
      model_zero_history();
    end else if (bus.sample_tick) begin
      m_e[2] = m_e[1];
      m_e[1] = m_e[0];
      m_e[0] = clamp(longint'(bus.refk) - longint'(bus.yk));
      acc = m_u_prev;
      acc = wrap_acc(acc + wrap_acc((longint'(bus.a0) * m_e[0]) >>> F));
      acc = wrap_acc(acc + wrap_acc((longint'(bus.a1) * m_e[1]) >>> F));
      acc = wrap_acc(acc + wrap_acc((longint'(bus.a2) * m_e[2]) >>> F));
      m_res = clamp(acc);
      left  = 4;
    end
    exp_busy = (left > 0) ? 1 : 0;
  endtask

  // Per-cycle compare on the falling edge, then advance the model for the next edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      check("u_out",   longint'(bus.u_out), exp_u);
      check("u_valid", longint'(bus.u_valid), exp_valid);
      check("busy",    longint'(bus.busy), exp_busy);
      check("overrun", longint'(bus.overrun), exp_over);
      if (rst_n) model_advance();
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic t, input logic c, input int r, input int y,
                       input int k0, input int k1, input int k2);
    bus.sample_tick = t;
    bus.clear       = c;
    bus.refk        = N'(r);
    bus.yk          = N'(y);
    bus.a0          = N'(k0);
    bus.a1          = N'(k1);
    bus.a2          = N'(k2);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
  endtask

  task automatic run_step(input string name, input int r, input int y, input int k0,
                          input int k1, input int k2, input longint lit);
    int     cnt;
    longint got;
    longint u;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, r, y, k0, k1, k2);
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    cnt = 0; got = 0; u = 0;
    for (int i = 0; i < 12 && got == 0; i++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
      if (bus.u_valid) begin
        got = 1;
        u   = longint'(bus.u_out);
      end
    end
    check({name, "_seen"}, got, 1);
    check(name, u, lit);
    check({name, "_busycycles"}, cnt, 4);
  endtask

  initial begin
    logic [31:0] rv;
    int          vcnt;
    longint      vu;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    #2;
    check("rst_u_out", longint'(bus.u_out), 0);
    check("rst_busy", longint'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Integrator
    run_step("int1", 512, 0, 512, 0, 0, 512);
    run_step("int2", 512, 0, 512, 0, 0, 1024);

    // History through a1, then a2
    do_clear();
    run_step("h1_0", 512, 0, 0, 512, 0, 0);
    run_step("h1_1", 0, 0, 0, 512, 0, 512);
    run_step("h1_2", 0, 0, 0, 512, 0, 512);
    do_clear();
    run_step("h2_0", 512, 0, 0, 0, 512, 0);
    run_step("h2_1", 0, 0, 0, 0, 512, 0);
    run_step("h2_2", 0, 0, 0, 0, 512, 512);

    // Saturation of error and of the accumulator
    do_clear();
    run_step("satp1", 131071, -131072, 512, 0, 0, 131071);
    run_step("satp2", 131071, -131072, 512, 0, 0, 131071);
    do_clear();
    run_step("satn1", -131072, 131071, 512, 0, 0, -131072);
    run_step("satn2", -131072, 131071, 512, 0, 0, -131072);

    // Truncation toward -infinity
    do_clear();
    run_step("trunc", 0, 1, 1, 0, 0, -1);

    // Tick during MAC1 is dropped
    do_clear();
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 512, 0, 512, 0, 0);
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    @(posedge clk); #1;
    bus.sample_tick = 1'b1;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    @(negedge clk);
    check("ovr_pulse", longint'(bus.overrun), 1);
    vcnt = 0; vu = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.u_valid) begin
        vcnt++;
        vu = longint'(bus.u_out);
      end
    end
    check("ovr_nvalid", vcnt, 1);
    check("ovr_result", vu, 512);

    // Clear during MAC0 aborts and wipes history
    do_clear();
    run_step("pre_abort", 512, 0, 512, 0, 0, 512);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 512, 0, 512, 512, 512);
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    bus.clear       = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.u_valid) vcnt++;
    end
    check("abort_nvalid", vcnt, 0);
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_uhold", longint'(bus.u_out), 512);
    run_step("post_abort", 512, 0, 512, 512, 512, 512);

    // Asynchronous reset mid-sequence
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 512, 0, 512, 0, 0);
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_u_out", longint'(bus.u_out), 0);
    check("arst_busy", longint'(bus.busy), 0);
    check("arst_valid", longint'(bus.u_valid), 0);
    check("arst_overrun", longint'(bus.overrun), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_step("post_rst", 512, 0, 512, 512, 0, 512);

    // Randomized traffic, checked only by the per-cycle model compare
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      rv = $urandom;
      drive((rv[1:0] == 2'b00), (rv[7:3] == 5'd0),
            int'($urandom), int'($urandom),
            int'($urandom_range(0, 4096)) - 2048,
            int'($urandom_range(0, 4096)) - 2048,
            int'($urandom_range(0, 4096)) - 2048);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
